// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// sequencer states, iteration count and operand helpers.
package mdu_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } md_state_e;

    localparam int         ITER     = 32;
    localparam logic [4:0] CNT_LAST = 5'(ITER - 1);

    function automatic logic [31:0] mag32(input logic [31:0] v);
        if (v[31]) begin
            return 32'd0 - v;
        end else begin
            return v;
        end
    endfunction

    function automatic logic op_is_div(input md_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU loop: shift-add for multiply, restoring
// trial-subtract for divide. Purely combinational.
module mdu_step
    import mdu_pkg::*;
(
    input  md_op_e      i_op,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic [32:0] w_sum;
    logic [32:0] w_add;
    logic [32:0] w_rsh;
    logic [31:0] w_diff;
    logic        w_geq;

    // Next {hi, lo} pair for the selected operation.
    always_comb begin
        w_sum  = {1'b0, i_hi} + {1'b0, i_b};
        w_add  = {1'b0, i_hi};
        w_rsh  = {i_hi, i_lo[31]};
        // The difference fits in 32 bits whenever the trial subtract succeeds.
        w_geq  = (w_rsh >= {1'b0, i_b});
        w_diff = w_rsh[31:0] - i_b;
        o_hi   = 32'd0;
        o_lo   = 32'd0;
        if (op_is_div(i_op)) begin
            o_hi = w_geq ? w_diff : w_rsh[31:0];
            o_lo = {i_lo[30:0], w_geq};
        end else begin
            w_add = i_lo[0] ? w_sum : {1'b0, i_hi};
            o_hi  = w_add[32:1];
            o_lo  = {w_add[0], i_lo[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO registers and the
// EX-stage interlock toward the hazard unit.
module muldiv_ctrl
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MdStart_ex,
    input  logic [1:0]      MdOp_ex,
    input  logic [XLEN-1:0] MdA_ex,
    input  logic [XLEN-1:0] MdB_ex,
    input  logic            MfHiLo_ex,
    input  logic            MtHi_ex,
    input  logic            MtLo_ex,
    output logic [XLEN-1:0] Hi,
    output logic [XLEN-1:0] Lo,
    output logic            MdBusy,
    output logic            MdDone,
    output logic            MdStall
);

    md_state_e   r_state;
    md_op_e      r_op;
    logic [4:0]  r_cnt;
    logic [31:0] r_acc;
    logic [31:0] r_quo;
    logic [31:0] r_b;
    logic [31:0] r_a_raw;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    logic [31:0] w_step_hi;
    logic [31:0] w_step_lo;
    logic [63:0] w_prod;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;
    md_op_e      w_op;
    logic        w_signed;

    assign w_op     = md_op_e'(MdOp_ex);
    assign w_signed = ~MdOp_ex[0];

    mdu_step u_step (
        .i_op (r_op),
        .i_hi (r_acc),
        .i_lo (r_quo),
        .i_b  (r_b),
        .o_hi (w_step_hi),
        .o_lo (w_step_lo)
    );

    // Sign correction and special cases applied in FIX before committing.
    always_comb begin
        w_prod     = {r_acc, r_quo};
        w_prod_fix = r_neg_q ? (64'd0 - w_prod) : w_prod;
        w_quo_fix  = r_neg_q ? (32'd0 - r_quo) : r_quo;
        w_rem_fix  = r_neg_r ? (32'd0 - r_acc) : r_acc;
        w_fix_hi   = w_prod_fix[63:32];
        w_fix_lo   = w_prod_fix[31:0];
        if (op_is_div(r_op)) begin
            if (r_dz) begin
                w_fix_hi = r_a_raw;
                w_fix_lo = 32'hFFFF_FFFF;
            end else begin
                w_fix_hi = w_rem_fix;
                w_fix_lo = w_quo_fix;
            end
        end else begin
            w_fix_hi = w_prod_fix[63:32];
            w_fix_lo = w_prod_fix[31:0];
        end
    end

    // Sequencer FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= MD_MULT;
            r_cnt   <= 5'd0;
            r_acc   <= 32'd0;
            r_quo   <= 32'd0;
            r_b     <= 32'd0;
            r_a_raw <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (MdStart_ex) begin
                        r_op    <= w_op;
                        r_quo   <= w_signed ? mag32(MdA_ex) : MdA_ex;
                        r_b     <= w_signed ? mag32(MdB_ex) : MdB_ex;
                        r_a_raw <= MdA_ex;
                        r_neg_q <= w_signed & (MdA_ex[31] ^ MdB_ex[31]);
                        r_neg_r <= w_signed & MdA_ex[31];
                        r_dz    <= MdOp_ex[1] & (MdB_ex == 32'd0);
                        r_acc   <= 32'd0;
                        r_cnt   <= 5'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        if (MtHi_ex) begin
                            r_hi <= MdA_ex;
                        end
                        if (MtLo_ex) begin
                            r_lo <= MdA_ex;
                        end
                    end
                end
                ST_RUN: begin
                    r_acc <= w_step_hi;
                    r_quo <= w_step_lo;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Hi      = r_hi;
    assign Lo      = r_lo;
    assign MdBusy  = r_busy;
    assign MdDone  = r_done;
    assign MdStall = r_busy & (MdStart_ex | MfHiLo_ex | MtHi_ex | MtLo_ex);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected HI/LO pushed at start,
// popped and compared on every MdDone.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MdStart_ex;
    logic [1:0]  MdOp_ex;
    logic [31:0] MdA_ex;
    logic [31:0] MdB_ex;
    logic        MfHiLo_ex;
    logic        MtHi_ex;
    logic        MtLo_ex;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        MdBusy;
    logic        MdDone;
    logic        MdStall;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [63:0] exp_q[$];

    muldiv_ctrl #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .MdStart_ex (MdStart_ex),
        .MdOp_ex    (MdOp_ex),
        .MdA_ex     (MdA_ex),
        .MdB_ex     (MdB_ex),
        .MfHiLo_ex  (MfHiLo_ex),
        .MtHi_ex    (MtHi_ex),
        .MtLo_ex    (MtLo_ex),
        .Hi         (Hi),
        .Lo         (Lo),
        .MdBusy     (MdBusy),
        .MdDone     (MdDone),
        .MdStall    (MdStall)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model written from the architectural definition.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic        [31:0] q;
        logic        [31:0] r;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                sp = $signed(a) * $signed(b);
                return sp;
            end
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        MdStart_ex = 1'b1;
        MdOp_ex    = op;
        MdA_ex     = a;
        MdB_ex     = b;
        exp_q.push_back(exp);
        tick();
        MdStart_ex = 1'b0;
    endtask

    task automatic wait_done(input int lat_exp);
        int n;
        int busy;
        n    = 0;
        busy = MdBusy ? 1 : 0;
        while (!MdDone && n < 40) begin
            tick();
            n++;
            if (MdBusy) busy++;
        end
        check_val("done_latency", 64'(n), 64'(lat_exp));
        check_val("busy_cycles", 64'(busy), 64'(lat_exp));
        tick();
        check_val("done_pulse", 64'(MdDone), 64'd0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        start_op(op, a, b, exp);
        wait_done(33);
    endtask

    // Scoreboard consumer: every committed result must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && MdDone) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_done", 64'(MdDone), 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check_val("hi", 64'(Hi), 64'(e[63:32]));
                check_val("lo", 64'(Lo), 64'(e[31:0]));
            end
        end
    end

    initial begin
        int t0;
        int n;
        int g;
        int acc_c;
        logic [31:0] lo_prev;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1; MdStart_ex = 1'b0; MdOp_ex = 2'b00; MdA_ex = 32'd0; MdB_ex = 32'd0;
        MfHiLo_ex = 1'b0; MtHi_ex = 1'b0; MtLo_ex = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check_val("rst_hi", 64'(Hi), 64'd0);
        check_val("rst_lo", 64'(Lo), 64'd0);
        check_val("rst_busy", 64'(MdBusy), 64'd0);
        check_val("rst_done", 64'(MdDone), 64'd0);
        check_val("rst_stall", 64'(MdStall), 64'd0);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7,          {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0000_0000});
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(2'b10, 32'd7,         32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD});
        run_op(2'b11, 32'd100,       32'd7,          {32'd2, 32'd14});
        run_op(2'b11, 32'd5,         32'd0,          {32'd5, 32'hFFFF_FFFF});
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0,          {32'hFFFF_FFF9, 32'hFFFF_FFFF});
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            run_op(rop, ra, rb, model(rop, ra, rb));
        end

        // MTLO / MTHI in IDLE write at the next edge.
        MtLo_ex = 1'b1; MdA_ex = 32'h0000_1234;
        tick();
        MtLo_ex = 1'b0;
        check_val("mtlo_idle", 64'(Lo), 64'h1234);
        MtHi_ex = 1'b1; MdA_ex = 32'h0000_5678;
        tick();
        MtHi_ex = 1'b0;
        check_val("mthi_idle", 64'(Hi), 64'h5678);

        // MTLO while busy must not be consumed.
        lo_prev = Lo;
        start_op(2'b11, 32'd1000, 32'd10, model(2'b11, 32'd1000, 32'd10));
        MtLo_ex = 1'b1; MdA_ex = 32'hDEAD_BEEF;
        #1;
        check_val("mt_busy_stall", 64'(MdStall), 64'd1);
        tick();
        MtLo_ex = 1'b0;
        check_val("mt_busy_ignored", 64'(Lo), 64'(lo_prev));
        wait_done(32);

        // MFHI presented at T+5 stalls through T+33.
        t0 = cyc;
        start_op(2'b00, 32'd5, 32'd6, model(2'b00, 32'd5, 32'd6));
        repeat (4) tick();
        MfHiLo_ex = 1'b1;
        n = 0;
        while (cyc - t0 <= 33) begin
            #1;
            if (MdStall) n++;
            tick();
        end
        #1;
        check_val("mf_stall_cycles", 64'(n), 64'd29);
        check_val("mf_stall_release", 64'(MdStall), 64'd0);
        check_val("mf_done_t34", 64'(MdDone), 64'd1);
        MfHiLo_ex = 1'b0;
        tick();

        // Second MULT held from T+1 is accepted at T+34, done at T+68.
        t0 = cyc;
        start_op(2'b00, 32'hFFFF_FF00, 32'd3, model(2'b00, 32'hFFFF_FF00, 32'd3));
        MdStart_ex = 1'b1; MdOp_ex = 2'b00; MdA_ex = 32'd12345; MdB_ex = 32'hFFFF_FFF0;
        #1;
        g = 0;
        while (MdStall && g < 60) begin
            tick();
            g++;
        end
        acc_c = cyc;
        exp_q.push_back(model(2'b00, 32'd12345, 32'hFFFF_FFF0));
        tick();
        MdStart_ex = 1'b0;
        check_val("b2b_accept", 64'(acc_c - t0), 64'd34);
        g = 0;
        while (!MdDone && g < 60) begin
            tick();
            g++;
        end
        check_val("b2b_done", 64'(cyc - t0), 64'd68);
        tick();

        // Reset at T+10 of a DIV: state clears at once, no result commits.
        start_op(2'b10, 32'hFFFF_0000, 32'd3, model(2'b10, 32'hFFFF_0000, 32'd3));
        repeat (9) tick();
        reset = 1'b1;
        #1;
        check_val("abort_busy", 64'(MdBusy), 64'd0);
        check_val("abort_hi", 64'(Hi), 64'd0);
        check_val("abort_lo", 64'(Lo), 64'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (MdDone) n++;
        end
        check_val("abort_no_done", 64'(n), 64'd0);
        run_op(2'b01, 32'd2, 32'd3, {32'd0, 32'd6});

        repeat (2) tick();
        check_val("queue_drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
